// File: rtl/result_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_packer_pkg
// Purpose  : Shared constants, typedefs and helpers for the result packer.
// Revision : 1.0 - initial release
// ============================================================================
package result_packer_pkg;

    // Default configuration of the packer
    localparam int c_DATA_WIDTH  = 8;
    localparam int c_INDEX_WIDTH = 10;
    localparam int c_CELL_AMOUNT = 4;
    localparam int c_FIFO_DEPTH  = 4;

    // Packed-word width: one DATA_WIDTH slot per cell
    localparam int c_WORD_WIDTH  = c_DATA_WIDTH * c_CELL_AMOUNT;

    // Slot index and FIFO pointer widths (pointer carries one extra wrap bit)
    localparam int c_SLOT_WIDTH  = $clog2(c_CELL_AMOUNT);
    localparam int c_PTR_WIDTH   = $clog2(c_FIFO_DEPTH) + 1;

    typedef logic [c_SLOT_WIDTH-1:0] slot_t;
    typedef logic [c_PTR_WIDTH-1:0]  fifo_ptr_t;

    // Width of a packed word for an arbitrary configuration
    function automatic int word_width(input int data_width, input int cell_amount);
        return data_width * cell_amount;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : packer_fifo
// Purpose  : Small synchronous FIFO holding completed packed words. Pointers
//            carry an extra wrap bit so full and empty are distinguishable.
//            A push into a full FIFO is accepted when a pop happens in the
//            same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module packer_fifo
    import result_packer_pkg::*;
#(
    parameter int WIDTH = c_WORD_WIDTH,
    parameter int DEPTH = c_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Head word comes straight from the storage registers
    assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update; reset clears contents so the head reads 0
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// Module   : result_packer
// Purpose  : Collects CELL_AMOUNT in-order scaled values into one packed word,
//            buffers words in packer_fifo and streams them out over a
//            valid/ready handshake. Sticky overflow / sequence_error flags.
//            Optional statistics (word_count, drop_count) are built when the
//            macro RESULT_PACKER_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module result_packer
    import result_packer_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DATA_WIDTH,
    parameter int INDEX_WIDTH = c_INDEX_WIDTH,
    parameter int CELL_AMOUNT = c_CELL_AMOUNT,
    parameter int FIFO_DEPTH  = c_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [INDEX_WIDTH-1:0]            input_index,
    input  logic [DATA_WIDTH-1:0]             input_value,
    input  logic                              input_enable,
    output logic [DATA_WIDTH*CELL_AMOUNT-1:0] output_data,
`ifdef RESULT_PACKER_STATS_EN
    output logic [15:0]                       word_count,
    output logic [7:0]                        drop_count,
`endif
    output logic                              output_valid,
    input  logic                              output_ready,
    output logic                              overflow,
    output logic                              sequence_error
);

    localparam int                WORD_W      = word_width(DATA_WIDTH, CELL_AMOUNT);
    localparam int                SLOT_W      = $clog2(CELL_AMOUNT);
    localparam logic [SLOT_W-1:0] c_LAST_SLOT = SLOT_W'(CELL_AMOUNT - 1);

    // Collector state
    logic [SLOT_W-1:0] r_expected;
    logic [WORD_W-1:0] r_partial;

    // Completed word waiting one cycle before entering the FIFO
    logic              r_push_valid;
    logic [WORD_W-1:0] r_push_data;

    logic              r_overflow;
    logic              r_seq_error;

    logic              w_index_match;
    logic              w_index_zero;
    logic [WORD_W-1:0] w_merged;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_push_accept;
    logic              w_drop;

    assign w_index_match = (input_index == INDEX_WIDTH'(r_expected));
    assign w_index_zero  = (input_index == '0);

    assign output_valid  = !w_fifo_empty;
    assign w_pop         = output_valid && output_ready;
    assign w_push_accept = r_push_valid && (!w_fifo_full || w_pop);
    assign w_drop        = r_push_valid && w_fifo_full && !w_pop;

    assign overflow       = r_overflow;
    assign sequence_error = r_seq_error;

    // Partial word with the incoming value merged into the expected slot
    always_comb begin
        w_merged = r_partial;
        w_merged[int'(r_expected)*DATA_WIDTH +: DATA_WIDTH] = input_value;
    end

    // Collector: track expected index, build the word, hand off completed words
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_expected   <= '0;
            r_partial    <= '0;
            r_push_valid <= 1'b0;
            r_push_data  <= '0;
            r_seq_error  <= 1'b0;
        end else begin
            r_push_valid <= 1'b0;
            if (input_enable) begin
                if (w_index_match) begin
                    if (r_expected == c_LAST_SLOT) begin
                        r_push_valid <= 1'b1;
                        r_push_data  <= w_merged;
                        r_partial    <= '0;
                        r_expected   <= '0;
                    end else begin
                        r_partial    <= w_merged;
                        r_expected   <= r_expected + SLOT_W'(1);
                    end
                end else if (w_index_zero) begin
                    // Out-of-order index 0 starts a fresh word
                    r_seq_error <= 1'b1;
                    r_partial   <= WORD_W'(input_value);
                    r_expected  <= SLOT_W'(1);
                end else begin
                    r_seq_error <= 1'b1;
                    r_partial   <= '0;
                    r_expected  <= '0;
                end
            end
        end
    end

    // Sticky overflow: a completed word found the FIFO full with no pop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    packer_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push_accept),
        .push_data (r_push_data),
        .full      (w_fifo_full),
        .pop       (w_pop),
        .pop_data  (output_data),
        .empty     (w_fifo_empty)
    );

`ifdef RESULT_PACKER_STATS_EN
    logic [15:0] r_word_count;
    logic [7:0]  r_drop_count;

    // Wrapping count of accepted words, saturating count of dropped words
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_word_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push_accept) begin
                r_word_count <= r_word_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign word_count = r_word_count;
    assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire
